// File: rtl/lcd_fifo_scanout.sv
// LCD raster scan-out: drains a first-word-fall-through FIFO of packed RGB565 pairs
// and drives registered sync/DE/pixel outputs, substituting a fixed colour on under-run.
module lcd_fifo_scanout #(
  parameter int          H_ACTIVE  = 480,
  parameter int          H_FP      = 8,
  parameter int          H_SYNC    = 4,
  parameter int          H_BP      = 43,
  parameter int          V_ACTIVE  = 272,
  parameter int          V_FP      = 4,
  parameter int          V_SYNC    = 4,
  parameter int          V_BP      = 12,
  parameter logic [15:0] UFL_COLOR = 16'hF800
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  input  logic        enable,
  input  logic [31:0] fifo_data,
  input  logic        fifo_vld,
  output logic        fifo_en,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        frame_start,
  output logic [15:0] ufl_cnt
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW    = $clog2(H_TOT + 1);
  localparam int VW    = $clog2(V_TOT + 1);

  localparam logic [HW-1:0] H_ZERO     = HW'(0);
  localparam logic [HW-1:0] H_ONE      = HW'(1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_ZERO     = VW'(0);
  localparam logic [VW-1:0] V_ONE      = VW'(1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_act;
  logic          v_act;
  logic          act;
  logic          phase;
  logic [15:0]   pixel;

  // Active-region decode, pixel select and the combinational pop strobe.
  always_comb begin
    h_act = (h >= H_ACT_BEG) && (h < H_ACT_END);
    v_act = (v >= V_ACT_BEG) && (v < V_ACT_END);
    act   = (state == RUN) && h_act && v_act;
    // Column parity without a subtractor: col[0] = h[0] ^ start[0].
    phase = h[0] ^ H_ACT_BEG[0];
    if (fifo_vld) begin
      pixel = phase ? fifo_data[31:16] : fifo_data[15:0];
    end else begin
      pixel = UFL_COLOR;
    end
    fifo_en = act && phase && fifo_vld;
  end

  // Scan FSM, raster counters, under-run counter and registered LCD outputs.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state       <= IDLE;
      h           <= H_ZERO;
      v           <= V_ZERO;
      lcd_hs      <= 1'b1;
      lcd_vs      <= 1'b1;
      lcd_de      <= 1'b0;
      lcd_rgb     <= 16'h0000;
      frame_start <= 1'b0;
      ufl_cnt     <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          h           <= H_ZERO;
          v           <= V_ZERO;
          lcd_hs      <= 1'b1;
          lcd_vs      <= 1'b1;
          lcd_de      <= 1'b0;
          lcd_rgb     <= 16'h0000;
          frame_start <= 1'b0;
          if (enable) begin
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          lcd_hs      <= (h >= H_SYNC_END);
          lcd_vs      <= (v >= V_SYNC_END);
          lcd_de      <= act;
          lcd_rgb     <= act ? pixel : 16'h0000;
          frame_start <= (h == H_ZERO) && (v == V_ZERO);
          if (act && !fifo_vld && (ufl_cnt != 16'hFFFF)) begin
            ufl_cnt <= ufl_cnt + 16'h0001;
          end
          // Enable is only honoured at the frame boundary.
          if (h == H_LAST) begin
            h <= H_ZERO;
            if (v == V_LAST) begin
              v <= V_ZERO;
              if (!enable) begin
                state <= IDLE;
              end
            end else begin
              v <= v + V_ONE;
            end
          end else begin
            h <= h + H_ONE;
          end
        end
        default: begin
          state <= IDLE;
          h     <= H_ZERO;
          v     <= V_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_fifo_scanout.sv
// Directed bench for lcd_fifo_scanout on a 7x5 raster (4x2 active), with a queue
// standing in for the first-word-fall-through FIFO.
module tb_lcd_fifo_scanout;

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        enable;
  logic [31:0] fifo_data;
  logic        fifo_vld;
  logic        fifo_en;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_de;
  logic [15:0] lcd_rgb;
  logic        frame_start;
  logic [15:0] ufl_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  int          pops = 0;
  logic [31:0] q[$];
  logic [15:0] exp_px[$];
  bit          gate = 1'b0;

  lcd_fifo_scanout #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .UFL_COLOR(16'hF800)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable),
    .fifo_data(fifo_data), .fifo_vld(fifo_vld), .fifo_en(fifo_en),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
    .frame_start(frame_start), .ufl_cnt(ufl_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  // Expected raster, indexed by clocks since the first RUN cycle (h=v=0).
  function automatic logic e_hs(int j);
    return (j % 7) != 0;
  endfunction
  function automatic logic e_vs(int j);
    return ((j / 7) % 5) != 0;
  endfunction
  function automatic logic e_de(int j);
    int h = j % 7;
    int v = (j / 7) % 5;
    return (h >= 2) && (h <= 5) && (v >= 2) && (v <= 3);
  endfunction
  function automatic logic e_odd(int j);
    int h = j % 7;
    return e_de(j) && ((h == 3) || (h == 5));
  endfunction

  task automatic upd();
    fifo_vld  = gate && (q.size() > 0);
    fifo_data = (q.size() > 0) ? q[0] : 32'h0000_0000;
  endtask

  // Move past the next rising edge; pop the head if it was taken on that edge.
  task automatic advance(input logic took);
    @(posedge rd_clk);
    #1;
    if (took) begin
      void'(q.pop_front());
      pops++;
    end
    upd();
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    enable = 1'b0;
    gate   = 1'b0;
    q.delete();
    exp_px.delete();
    pops = 0;
    upd();
    @(posedge rd_clk); #1;
    @(posedge rd_clk); #1;
    rd_rst = 1'b0;
  endtask

  // Leaves the bench 1 ns into frame cycle 0.
  task automatic start_frame();
    enable = 1'b1;
    @(posedge rd_clk); #1;
  endtask

  task automatic test_reset();
    rd_rst = 1'b1;
    enable = 1'b1;
    gate   = 1'b1;
    q.delete();
    q.push_back(32'h1234_5678);
    upd();
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge rd_clk);
      vectors++;
      if ({lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start, ufl_cnt, fifo_en} !== {1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_values: got hs=%b vs=%b de=%b rgb=%h fs=%b ufl=%h en=%b, expected 1 1 0 0000 0 0000 0",
                 lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start, ufl_cnt, fifo_en);
      end
    end
    enable = 1'b0;
    @(posedge rd_clk); #1;
    rd_rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge rd_clk);
      vectors++;
      if ({lcd_hs, lcd_vs, lcd_de, frame_start, fifo_en} !== 5'b11000) begin
        miscompares++;
        $display("FAIL idle_hold: got hs=%b vs=%b de=%b fs=%b en=%b, expected 1 1 0 0 0",
                 lcd_hs, lcd_vs, lcd_de, frame_start, fifo_en);
      end
    end
  endtask

  task automatic test_scanout();
    logic en;
    logic [15:0] px;
    do_reset();
    q = '{32'hA001_A000, 32'hB001_B000, 32'hC001_C000, 32'hD001_D000};
    exp_px = '{16'hA000, 16'hA001, 16'hB000, 16'hB001, 16'hC000, 16'hC001, 16'hD000, 16'hD001};
    gate = 1'b1;
    upd();
    start_frame();
    for (int k = 0; k < 36; k++) begin
      @(negedge rd_clk);
      en = fifo_en;
      vectors++;
      if (en !== e_odd(k)) begin
        miscompares++;
        $display("FAIL scan_pop k=%0d: got fifo_en=%b expected %b", k, en, e_odd(k));
      end
      if (k > 0) begin
        vectors++;
        if (lcd_de !== e_de(k - 1)) begin
          miscompares++;
          $display("FAIL scan_de j=%0d: got %b expected %b", k - 1, lcd_de, e_de(k - 1));
        end
        px = (e_de(k - 1) && exp_px.size() > 0) ? exp_px.pop_front() : 16'h0000;
        vectors++;
        if (lcd_rgb !== px) begin
          miscompares++;
          $display("FAIL scan_rgb j=%0d: got %h expected %h", k - 1, lcd_rgb, px);
        end
      end
      advance(en);
    end
    vectors++;
    if (pops !== 4) begin
      miscompares++;
      $display("FAIL scan_pop_count: got %0d expected 4", pops);
    end
    vectors++;
    if (ufl_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL scan_ufl: got %h expected 0000", ufl_cnt);
    end
  endtask

  task automatic test_timing();
    logic en;
    do_reset();
    start_frame();
    for (int k = 0; k < 37; k++) begin
      @(negedge rd_clk);
      en = fifo_en;
      if (k > 0) begin
        vectors++;
        if ({lcd_hs, lcd_vs, frame_start} !== {e_hs(k - 1), e_vs(k - 1), ((k - 1) % 35) == 0}) begin
          miscompares++;
          $display("FAIL timing j=%0d: got hs=%b vs=%b fs=%b expected %b %b %b", k - 1,
                   lcd_hs, lcd_vs, frame_start, e_hs(k - 1), e_vs(k - 1), ((k - 1) % 35) == 0);
        end
      end
      advance(en);
    end
  endtask

  task automatic test_underrun();
    logic en;
    do_reset();
    start_frame();
    for (int k = 0; k < 36; k++) begin
      @(negedge rd_clk);
      en = fifo_en;
      vectors++;
      if (en !== 1'b0) begin
        miscompares++;
        $display("FAIL ufl_pop k=%0d: got fifo_en=%b expected 0", k, en);
      end
      if (k > 0 && e_de(k - 1)) begin
        vectors++;
        if ({lcd_de, lcd_rgb} !== {1'b1, 16'hF800}) begin
          miscompares++;
          $display("FAIL ufl_rgb j=%0d: got de=%b rgb=%h expected 1 f800", k - 1, lcd_de, lcd_rgb);
        end
      end
      advance(en);
    end
    vectors++;
    if (ufl_cnt !== 16'd8) begin
      miscompares++;
      $display("FAIL ufl_count: got %0d expected 8", ufl_cnt);
    end
  endtask

  task automatic test_late_word();
    logic en;
    logic [15:0] px;
    do_reset();
    q = '{32'h1111_1000, 32'h2221_2220, 32'h3331_3330, 32'h4441_4440};
    exp_px = '{16'hF800, 16'h1111, 16'h2220, 16'h2221, 16'h3330, 16'h3331, 16'h4440, 16'h4441};
    upd();
    start_frame();
    for (int k = 0; k < 36; k++) begin
      @(negedge rd_clk);
      en = fifo_en;
      vectors++;
      if (en !== e_odd(k)) begin
        miscompares++;
        $display("FAIL late_pop k=%0d: got fifo_en=%b expected %b", k, en, e_odd(k));
      end
      if (k > 0 && e_de(k - 1)) begin
        px = (exp_px.size() > 0) ? exp_px.pop_front() : 16'h0000;
        vectors++;
        if (lcd_rgb !== px) begin
          miscompares++;
          $display("FAIL late_rgb j=%0d: got %h expected %h", k - 1, lcd_rgb, px);
        end
      end
      advance(en);
      if (k == 16) begin
        gate = 1'b1;
        upd();
      end
    end
    vectors++;
    if (pops !== 4) begin
      miscompares++;
      $display("FAIL late_pop_count: got %0d expected 4", pops);
    end
    vectors++;
    if (ufl_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL late_ufl: got %0d expected 1", ufl_cnt);
    end
  endtask

  task automatic test_enable_drop();
    logic en;
    do_reset();
    start_frame();
    for (int k = 0; k < 41; k++) begin
      @(negedge rd_clk);
      en = fifo_en;
      if (k > 0 && k < 36) begin
        vectors++;
        if ({lcd_hs, lcd_vs, lcd_de} !== {e_hs(k - 1), e_vs(k - 1), e_de(k - 1)}) begin
          miscompares++;
          $display("FAIL drop_frame j=%0d: got hs=%b vs=%b de=%b expected %b %b %b", k - 1,
                   lcd_hs, lcd_vs, lcd_de, e_hs(k - 1), e_vs(k - 1), e_de(k - 1));
        end
      end else if (k >= 36) begin
        vectors++;
        if ({lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start, en} !== {1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
          miscompares++;
          $display("FAIL drop_idle k=%0d: got hs=%b vs=%b de=%b rgb=%h fs=%b en=%b expected 1 1 0 0000 0 0",
                   k, lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start, en);
        end
      end
      advance(en);
      if (k == 9) enable = 1'b0;
    end
    start_frame();
    @(posedge rd_clk); #1;
    vectors++;
    if ({frame_start, lcd_hs, lcd_vs} !== 3'b100) begin
      miscompares++;
      $display("FAIL drop_restart: got fs=%b hs=%b vs=%b expected 1 0 0", frame_start, lcd_hs, lcd_vs);
    end
  endtask

  task automatic test_mid_reset();
    logic en;
    do_reset();
    q = '{32'h5551_5550, 32'h6661_6660};
    upd();
    start_frame();
    for (int k = 0; k < 18; k++) begin
      @(negedge rd_clk);
      en = fifo_en;
      advance(en);
    end
    vectors++;
    if (ufl_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL mid_pre_ufl: got %0d expected 2", ufl_cnt);
    end
    gate = 1'b1;
    upd();
    #2;
    rd_rst = 1'b1;
    #1;
    vectors++;
    if ({lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start, ufl_cnt} !== {1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL mid_reset_values: got hs=%b vs=%b de=%b rgb=%h fs=%b ufl=%h expected 1 1 0 0000 0 0000",
               lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start, ufl_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge rd_clk);
      vectors++;
      if (fifo_en !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_reset_pop c=%0d: got fifo_en=%b expected 0", c, fifo_en);
      end
      @(posedge rd_clk); #1;
    end
    rd_rst = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    rd_rst = 1'b1;
    enable = 1'b0;
    upd();
    test_reset();
    test_scanout();
    test_timing();
    test_underrun();
    test_late_word();
    test_enable_drop();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares == 0)
      $display("PASS");
    else
      $display("FAIL");
    $finish;
  end

endmodule
